inputc_nvc: RTL and testbench

INPUTC_NVC -- requirements
Module: inputc_nvc

---
 rtl/inputc_nvc_pkg.sv | 55 +++++
 rtl/inputc_nvc_ivc.sv | 58 +++++
 rtl/inputc_nvc.sv | 164 ++++++++++++++++
 tb/tb_inputc_nvc.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inputc_nvc_pkg.sv
// Shared definitions for the virtual-channel input controller: flit type codes,
// flit field positions, output port codes, per-VC state encoding and XY routing.
package inputc_nvc_pkg;

  typedef enum logic [2:0] {
    FLIT_NONE     = 3'd0,
    FLIT_HEAD     = 3'd1,
    FLIT_BODY     = 3'd2,
    FLIT_TAIL     = 3'd3,
    FLIT_HEADTAIL = 3'd4
  } flit_type_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_EAST  = 3'd2,
    PORT_SOUTH = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  typedef enum logic [1:0] {
    VC_IDLE   = 2'd0,
    VC_ROUTE  = 2'd1,
    VC_WAIT   = 2'd2,
    VC_ACTIVE = 2'd3
  } vc_state_e;

  // Flit layout: type in the low bits, then destination x and y coordinates.
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 3;
  localparam int DSTX_LSB = 3;
  localparam int DSTY_LSB = 7;
  localparam int COORD_W  = 4;

  function automatic logic is_head(input flit_type_e t);
    return (t == FLIT_HEAD) || (t == FLIT_HEADTAIL);
  endfunction

  function automatic logic is_tail(input flit_type_e t);
    return (t == FLIT_TAIL) || (t == FLIT_HEADTAIL);
  endfunction

  // Dimension-ordered routing: resolve x first, then y.
  function automatic port_e xy_route(input logic [3:0] dx, input logic [3:0] dy,
                                     input logic [3:0] mx, input logic [3:0] my);
    port_e p;
    if (dx > mx)      p = PORT_EAST;
    else if (dx < mx) p = PORT_WEST;
    else if (dy > my) p = PORT_SOUTH;
    else if (dy < my) p = PORT_NORTH;
    else              p = PORT_LOCAL;
    return p;
  endfunction

endpackage

// File: rtl/inputc_nvc_ivc.sv
// Per-virtual-channel circular flit buffer with a sticky overflow flag.
// A write into a full buffer is still accepted when a read frees a slot the same cycle.
module ivc_fifo #(
  parameter int DEPTH = 4,
  parameter int DATAW = 64
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [DATAW-1:0] din,
  output logic [DATAW-1:0] front,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATAW-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == {CW{1'b0}});
  assign pop_s  = rd_en && !empty;
  assign push_s = wr_en && (!full || pop_s);
  assign front  = mem_r[rd_ptr_r];

  // Flit storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers, occupancy and overflow; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      ovf      <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1'b1);
        2'b01:   count_r <= count_r - CW'(1'b1);
        default: count_r <= count_r;
      endcase
      if (wr_en && !push_s) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/inputc_nvc.sv
// Router input controller: NVC virtual-channel buffers, per-VC route/arbitration FSMs,
// round-robin switch request with packet locking, and a registered flit output stage.
module inputc_nvc
  import inputc_nvc_pkg::*;
#(
  parameter int ROUTERID = 0,
  parameter int PCHID    = 0,
  parameter int NVC      = 4,
  parameter int DEPTH    = 4,
  parameter int DATAW    = 64
) (
  input  logic                    clk,
  input  logic                    rst_,
  input  logic [DATAW-1:0]        idata,
  input  logic                    ivalid,
  input  logic [$clog2(NVC)-1:0]  ivch,
  output logic [NVC-1:0]          ordy,
  output logic [NVC-1:0]          oack,
  output logic [NVC-1:0]          olck,
  input  logic [5*NVC-1:0]        irdy,
  output logic                    req,
  output logic [2:0]              port,
  input  logic                    grt,
  output logic [DATAW-1:0]        odata,
  output logic                    ovalid,
  output logic [$clog2(NVC)-1:0]  ovch,
  input  logic [3:0]              my_xpos,
  input  logic [3:0]              my_ypos,
  output logic [NVC-1:0]          ovf
);

  localparam int VW = $clog2(NVC);

  if (NVC < 2 || NVC > 8 || DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      DATAW < DSTY_LSB + COORD_W || ROUTERID < 0 || PCHID < 0) begin : g_bad_param
    $error("inputc_nvc: illegal parameter set");
  end

  logic [DATAW-1:0] front_s [NVC];
  port_e            port_s  [NVC];
  logic [NVC-1:0]   wr_en_s;
  logic [NVC-1:0]   rd_en_s;
  logic [NVC-1:0]   full_s;
  logic [NVC-1:0]   empty_s;
  logic [NVC-1:0]   elig_s;
  logic [NVC-1:0]   active_s;
  logic [NVC-1:0]   discard_s;
  logic [VW-1:0]    rr_r;
  logic [VW-1:0]    sel_s;
  logic             sel_ok_s;
  logic             lock_s;
  logic             grant_s;

  for (genvar g = 0; g < NVC; g++) begin : g_vc
    vc_state_e  state_r;
    port_e      port_r;
    flit_type_e ftype_s;
    logic       irdy_s;

    ivc_fifo #(.DEPTH(DEPTH), .DATAW(DATAW)) u_fifo (
      .clk   (clk),
      .rst_  (rst_),
      .wr_en (wr_en_s[g]),
      .rd_en (rd_en_s[g]),
      .din   (idata),
      .front (front_s[g]),
      .full  (full_s[g]),
      .empty (empty_s[g]),
      .ovf   (ovf[g])
    );

    assign wr_en_s[g]   = ivalid && (ivch == VW'(g));
    assign ftype_s      = flit_type_e'(front_s[g][TYPE_LSB +: TYPE_W]);
    assign discard_s[g] = (state_r == VC_IDLE) && !empty_s[g] && !is_head(ftype_s);
    assign rd_en_s[g]   = discard_s[g] || (grant_s && (sel_s == VW'(g)));
    assign active_s[g]  = (state_r == VC_ACTIVE);
    assign elig_s[g]    = ((state_r == VC_WAIT) || (state_r == VC_ACTIVE)) && !empty_s[g] && irdy_s;
    assign port_s[g]    = port_r;

    // Downstream-ready bit for this VC on its routed output port.
    always_comb begin
      case (port_r)
        PORT_LOCAL: irdy_s = irdy[int'(PORT_LOCAL) * NVC + g];
        PORT_NORTH: irdy_s = irdy[int'(PORT_NORTH) * NVC + g];
        PORT_EAST:  irdy_s = irdy[int'(PORT_EAST)  * NVC + g];
        PORT_SOUTH: irdy_s = irdy[int'(PORT_SOUTH) * NVC + g];
        PORT_WEST:  irdy_s = irdy[int'(PORT_WEST)  * NVC + g];
        default:    irdy_s = 1'b0;
      endcase
    end

    // Per-VC packet FSM; the route is latched in ROUTE while the head sits at the front.
    always_ff @(posedge clk or posedge rst_) begin
      if (rst_) begin
        state_r <= VC_IDLE;
        port_r  <= PORT_LOCAL;
      end else begin
        case (state_r)
          VC_IDLE: begin
            if (!empty_s[g] && is_head(ftype_s)) state_r <= VC_ROUTE;
          end
          VC_ROUTE: begin
            port_r  <= xy_route(front_s[g][DSTX_LSB +: COORD_W], front_s[g][DSTY_LSB +: COORD_W],
                                my_xpos, my_ypos);
            state_r <= VC_WAIT;
          end
          VC_WAIT, VC_ACTIVE: begin
            if (rd_en_s[g]) state_r <= is_tail(ftype_s) ? VC_IDLE : VC_ACTIVE;
          end
          default: state_r <= VC_IDLE;
        endcase
      end
    end
  end

  assign ordy    = ~full_s;
  assign oack    = rd_en_s;
  assign olck    = active_s;
  assign req     = sel_ok_s;
  assign port    = port_s[sel_s];
  assign grant_s = sel_ok_s && grt;

  // VC selection: an ACTIVE VC holds the switch until its tail; otherwise round-robin from rr_r.
  always_comb begin
    logic [VW-1:0] idx;
    sel_s    = rr_r;
    sel_ok_s = 1'b0;
    lock_s   = |active_s;
    idx      = {VW{1'b0}};
    if (lock_s) begin
      for (int i = 0; i < NVC; i++) begin
        if (active_s[i]) sel_s = VW'(i);
        else             sel_s = sel_s;
      end
      sel_ok_s = elig_s[sel_s];
    end else begin
      for (int i = 0; i < NVC; i++) begin
        idx = VW'((int'(rr_r) + i) % NVC);
        if (!sel_ok_s && elig_s[idx]) begin
          sel_s    = idx;
          sel_ok_s = 1'b1;
        end else begin
          sel_ok_s = sel_ok_s;
        end
      end
    end
  end

  // Output flit register and round-robin pointer update.
  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      ovalid <= 1'b0;
      odata  <= {DATAW{1'b0}};
      ovch   <= {VW{1'b0}};
      rr_r   <= {VW{1'b0}};
    end else begin
      ovalid <= grant_s;
      odata  <= grant_s ? front_s[sel_s] : {DATAW{1'b0}};
      ovch   <= grant_s ? sel_s : {VW{1'b0}};
      if (grant_s) rr_r <= (sel_s == VW'(NVC - 1)) ? {VW{1'b0}} : sel_s + VW'(1'b1);
    end
  end

endmodule

// File: tb/tb_inputc_nvc.sv
// Directed self-checking bench for inputc_nvc (NVC=4, DEPTH=4, DATAW=64), router at (5,5).
module tb_inputc_nvc;
  import inputc_nvc_pkg::*;

  logic        clk;
  logic        rst_;
  logic [63:0] idata;
  logic        ivalid;
  logic [1:0]  ivch;
  logic [3:0]  ordy;
  logic [3:0]  oack;
  logic [3:0]  olck;
  logic [19:0] irdy;
  logic        req;
  logic [2:0]  port;
  logic        grt;
  logic [63:0] odata;
  logic        ovalid;
  logic [1:0]  ovch;
  logic [3:0]  my_xpos;
  logic [3:0]  my_ypos;
  logic [3:0]  ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic        mon_en = 1'b0;
  logic [63:0] mon_d[$];
  logic [1:0]  mon_c[$];

  inputc_nvc #(.ROUTERID(0), .PCHID(0), .NVC(4), .DEPTH(4), .DATAW(64)) dut (
    .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
    .ordy(ordy), .oack(oack), .olck(olck), .irdy(irdy), .req(req), .port(port),
    .grt(grt), .odata(odata), .ovalid(ovalid), .ovch(ovch),
    .my_xpos(my_xpos), .my_ypos(my_ypos), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture forwarded flits away from the active edge.
  always @(negedge clk) begin
    if (mon_en && ovalid) begin
      mon_d.push_back(odata);
      mon_c.push_back(ovch);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input flit_type_e t, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [31:0] tag);
    logic [63:0] f;
    f        = 64'd0;
    f[2:0]   = t;
    f[6:3]   = dx;
    f[10:7]  = dy;
    f[63:32] = tag;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic put(input logic [1:0] vc, input logic [63:0] d);
    ivalid = 1'b1;
    ivch   = vc;
    idata  = d;
    step();
    ivalid = 1'b0;
    idata  = 64'd0;
  endtask

  initial begin
    logic [63:0] f;
    logic [63:0] exp_d[6];
    logic [1:0]  exp_c[6];
    logic        acc_v;
    logic        acc_a;

    rst_ = 1'b1; idata = 64'd0; ivalid = 1'b0; ivch = 2'd0;
    irdy = 20'hFFFFF; grt = 1'b1; my_xpos = 4'd5; my_ypos = 4'd5;
    step(); step(); step();
    check("rst_ordy",   ordy,   4'hF);
    check("rst_ovalid", ovalid, 1'b0);
    check("rst_odata",  odata,  64'd0);
    check("rst_oack",   oack,   4'h0);
    check("rst_olck",   olck,   4'h0);
    check("rst_ovf",    ovf,    4'h0);
    rst_ = 1'b0;
    step();

    // HEADTAIL to own position: 4-cycle latency, local port, credit on VC0.
    f = mk(FLIT_HEADTAIL, 4'd5, 4'd5, 32'hA0);
    put(2'd0, f);
    step();
    check("lat_c2_req",    req,    1'b0);
    check("lat_c2_ovalid", ovalid, 1'b0);
    step();
    check("lat_c3_req",  req,  1'b1);
    check("lat_c3_port", port, 3'd0);
    check("lat_c3_oack", oack, 4'b0001);
    step();
    check("lat_c4_ovalid", ovalid, 1'b1);
    check("lat_c4_odata",  odata,  f);
    check("lat_c4_ovch",   ovch,   2'd0);
    check("lat_c4_oack",   oack,   4'h0);
    step();
    check("lat_c5_ovalid", ovalid, 1'b0);
    check("lat_c5_odata",  odata,  64'd0);

    // Non-head flit reaching an idle VC is discarded with a credit and no output.
    put(2'd3, mk(FLIT_BODY, 4'd5, 4'd5, 32'hB0));
    check("disc_oack", oack, 4'b1000);
    step();
    check("disc_oack_off", oack, 4'h0);
    step();
    check("disc_ovalid", ovalid, 1'b0);

    // Destination one column east -> east port.
    f = mk(FLIT_HEADTAIL, 4'd6, 4'd5, 32'hC0);
    put(2'd3, f);
    step(); step();
    check("east_req",  req,  1'b1);
    check("east_port", port, 3'd2);
    step();
    check("east_odata", odata, f);
    check("east_ovch",  ovch,  2'd3);

    // Same column, smaller y -> north; hold north-ready of VC1 low, then release.
    irdy = 20'hFFFDF;
    f = mk(FLIT_HEADTAIL, 4'd5, 4'd3, 32'hD0);
    put(2'd1, f);
    step(); step();
    check("blk_req",  req,  1'b0);
    check("blk_oack", oack, 4'h0);
    step();
    check("blk_ovalid", ovalid, 1'b0);
    irdy = 20'hFFFFF;
    #1;
    check("unblk_req",  req,  1'b1);
    check("north_port", port, 3'd1);
    step();
    check("unblk_ovalid", ovalid, 1'b1);
    check("unblk_odata",  odata,  f);
    check("unblk_ovch",   ovch,   2'd1);
    step();

    // Five flits into a 4-deep VC1 with no grant: fill, overflow, then drain four.
    grt = 1'b0;
    exp_d[0] = mk(FLIT_HEAD, 4'd5, 4'd5, 32'h10);
    exp_d[1] = mk(FLIT_BODY, 4'd5, 4'd5, 32'h11);
    exp_d[2] = mk(FLIT_BODY, 4'd5, 4'd5, 32'h12);
    exp_d[3] = mk(FLIT_TAIL, 4'd5, 4'd5, 32'h13);
    for (int i = 0; i < 4; i++) put(2'd1, exp_d[i]);
    check("full_ordy", ordy, 4'b1101);
    check("full_ovf0", ovf,  4'h0);
    put(2'd1, mk(FLIT_BODY, 4'd5, 4'd5, 32'h14));
    check("ovf_set",   ovf,  4'b0010);
    check("ovf_ordy",  ordy, 4'b1101);
    check("ovf_req",   req,  1'b1);
    grt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("drain%0d_ovalid", i), ovalid, 1'b1);
      check($sformatf("drain%0d_odata", i),  odata,  exp_d[i]);
    end
    step();
    check("drain_end_ovalid", ovalid, 1'b0);
    check("ovf_sticky",       ovf,    4'b0010);
    check("drain_ordy",       ordy,   4'hF);
    check("drain_olck",       olck,   4'h0);

    // Interleaved packets on VC0 and VC2 leave the switch contiguously, VC0 first.
    mon_d.delete(); mon_c.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_d[i]     = mk(i == 0 ? FLIT_HEAD : (i == 1 ? FLIT_BODY : FLIT_TAIL), 4'd5, 4'd5, 32'h20 + 32'(i));
      exp_c[i]     = 2'd0;
      exp_d[i + 3] = mk(i == 0 ? FLIT_HEAD : (i == 1 ? FLIT_BODY : FLIT_TAIL), 4'd5, 4'd5, 32'h30 + 32'(i));
      exp_c[i + 3] = 2'd2;
    end
    put(2'd0, exp_d[0]);
    put(2'd2, exp_d[3]);
    put(2'd0, exp_d[1]);
    put(2'd2, exp_d[4]);
    put(2'd0, exp_d[2]);
    check("il_olck_vc0", olck, 4'b0001);
    put(2'd2, exp_d[5]);
    for (int i = 0; i < 6; i++) step();
    mon_en = 1'b0;
    check("il_count", 64'(mon_d.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < mon_d.size()) begin
        check($sformatf("il%0d_odata", i), mon_d[i], exp_d[i]);
        check($sformatf("il%0d_ovch", i),  mon_c[i], exp_c[i]);
      end
    end
    check("il_olck_end", olck, 4'h0);

    // Reset mid-packet on VC2 with three flits buffered.
    put(2'd2, mk(FLIT_HEAD, 4'd5, 4'd5, 32'h40));
    put(2'd2, mk(FLIT_BODY, 4'd5, 4'd5, 32'h41));
    put(2'd2, mk(FLIT_BODY, 4'd5, 4'd5, 32'h42));
    put(2'd2, mk(FLIT_BODY, 4'd5, 4'd5, 32'h43));
    grt = 1'b0;
    step();
    check("mid_olck", olck, 4'b0100);
    rst_ = 1'b1;
    #1;
    check("mid_rst_ordy",   ordy,   4'hF);
    check("mid_rst_oack",   oack,   4'h0);
    check("mid_rst_olck",   olck,   4'h0);
    check("mid_rst_ovf",    ovf,    4'h0);
    check("mid_rst_ovalid", ovalid, 1'b0);
    check("mid_rst_odata",  odata,  64'd0);
    check("mid_rst_ovch",   ovch,   2'd0);
    check("mid_rst_req",    req,    1'b0);
    step();
    rst_ = 1'b0;
    grt  = 1'b1;
    acc_v = 1'b0;
    acc_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      acc_v = acc_v | ovalid;
      acc_a = acc_a | (|oack);
    end
    check("post_rst_no_ovalid", acc_v, 1'b0);
    check("post_rst_no_oack",   acc_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
